// File: rtl/regfile_pkg.sv
// Shared types and defaults for the integer register file and its busy scoreboard.
package regfile_pkg;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef logic [$clog2(DEF_NREGS)-1:0] reg_idx_t;
  typedef logic [DEF_XLEN-1:0]          xlen_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/regfile_scoreboard_busy_scoreboard.sv
// Per-register busy tracking for long-latency destinations, with an incremental
// outstanding count. Issue (set) beats retire (clear) on the same index.
module busy_scoreboard #(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS),
  localparam int CNT_W = $clog2(NREGS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    rd_sel,
  input  logic             sb_set_en,
  input  logic [AW-1:0]    sb_set_sel,
  output logic [NREGS-1:0] busy_vec,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             sb_full
);
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_hit, clr_hit, inc, dec;

  assign set_hit = sb_set_en && (sb_set_sel != '0);
  assign clr_hit = wr_en && (rd_sel != '0);

  always_comb begin
    busy_d = busy_q;
    if (clr_hit) busy_d[rd_sel]     = 1'b0;
    if (set_hit) busy_d[sb_set_sel] = 1'b1;
  end

  // A clear that collides with a set on the same index is swallowed by the set.
  assign inc   = set_hit && !busy_q[sb_set_sel];
  assign dec   = clr_hit && busy_q[rd_sel] && !(set_hit && (sb_set_sel == rd_sel));
  assign cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;
  assign sb_full  = (cnt_q == CNT_W'(NREGS - 1));
endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised 2R/1W register file (x0 hardwired to zero) with a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN  = DEF_XLEN,
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS),
  localparam int CNT_W = $clog2(NREGS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_sel,
  input  logic [AW-1:0]    rs2_sel,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic [AW-1:0]    rd_sel,
  input  logic [XLEN-1:0]  wr_data,
  input  logic             wr_en,
  input  logic             sb_set_en,
  input  logic [AW-1:0]    sb_set_sel,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             sb_full
);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic             wr_hit;

  assign wr_hit = wr_en && (rd_sel != ZERO_IDX);

  // Entry 0 is never written, so it reads zero straight from the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[rd_sel] <= wr_data;
    end
  end

  busy_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_sel    (rd_sel),
    .sb_set_en (sb_set_en),
    .sb_set_sel(sb_set_sel),
    .busy_vec  (busy_vec),
    .busy_cnt  (busy_cnt),
    .sb_full   (sb_full)
  );

`ifdef REGFILE_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1     = wr_hit && (rd_sel == rs1_sel);
  assign fwd2     = wr_hit && (rd_sel == rs2_sel);
  assign rs1_data = fwd1 ? wr_data : regs_q[rs1_sel];
  assign rs2_data = fwd2 ? wr_data : regs_q[rs2_sel];
  assign rs1_busy = busy_vec[rs1_sel] && !fwd1;
  assign rs2_busy = busy_vec[rs2_sel] && !fwd2;
`else
  assign rs1_data = regs_q[rs1_sel];
  assign rs2_data = regs_q[rs2_sel];
  assign rs1_busy = busy_vec[rs1_sel];
  assign rs2_busy = busy_vec[rs2_sel];
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard; expected read data is queued at drive
// time and popped when the read port is sampled.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_sel = '0, rs2_sel = '0, rd_sel = '0, sb_set_sel = '0;
  logic [31:0] rs1_data, rs2_data, wr_data = '0;
  logic        rs1_busy, rs2_busy, wr_en = 1'b0, sb_set_en = 1'b0;
  logic [5:0]  busy_cnt;
  logic        sb_full;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int          model_cnt;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rd_sel(rd_sel), .wr_data(wr_data), .wr_en(wr_en),
    .sb_set_en(sb_set_en), .sb_set_sel(sb_set_sel),
    .busy_cnt(busy_cnt), .sb_full(sb_full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; sb_set_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    tick(); rst = 1'b0;
    wr_en = 1'b1; rd_sel = 5'd4; wr_data = 32'hCAFE0004;
    tick();
    idle(); sb_set_en = 1'b1; sb_set_sel = 5'd6;
    tick();
    idle(); rs1_sel = 5'd4; rs2_sel = 5'd6;
    #1;
    if (rs1_data !== 32'hCAFE0004 || rs2_busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset got %h/%b exp cafe0004/1", rs1_data, rs2_busy);
    end
    checks++;
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front();
    if (rs1_data !== exp) begin errors++; $display("FAIL reset_data got %h exp %h", rs1_data, exp); end
    checks++;
    if (busy_cnt !== 6'd0 || sb_full !== 1'b0 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL reset_sb got cnt %0d full %b busy %b exp 0 0 0", busy_cnt, sb_full, rs2_busy);
    end
    checks++;
    tick(); rst = 1'b0;
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; rd_sel = 5'd5; wr_data = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    idle(); rs1_sel = 5'd5; #1;
    exp = exp_q.pop_front();
    if (rs1_data !== exp) begin errors++; $display("FAIL write_read got %h exp %h", rs1_data, exp); end
    checks++;
    wr_en = 1'b1; rd_sel = 5'd0; wr_data = 32'h1234;
    exp_q.push_back(32'h0);
    tick();
    idle(); rs2_sel = 5'd0; #1;
    exp = exp_q.pop_front();
    if (rs2_data !== exp || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL write_x0 got %h/%b exp %h/0", rs2_data, rs2_busy, exp);
    end
    checks++;
  endtask

  task automatic test_set_clear();
    sb_set_en = 1'b1; sb_set_sel = 5'd7;
    tick();
    idle(); rs2_sel = 5'd7; #1;
    if (rs2_busy !== 1'b1 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL sb_set got busy %b cnt %0d exp 1 1", rs2_busy, busy_cnt);
    end
    checks++;
    wr_en = 1'b1; rd_sel = 5'd7; wr_data = 32'h55;
    exp_q.push_back(32'h55);
    tick();
    idle(); #1;
    exp = exp_q.pop_front();
    if (rs2_busy !== 1'b0 || busy_cnt !== 6'd0 || rs2_data !== exp) begin
      errors++; $display("FAIL sb_clear got busy %b cnt %0d data %h exp 0 0 %h", rs2_busy, busy_cnt, rs2_data, exp);
    end
    checks++;
  endtask

  task automatic test_simul_set_clear();
    sb_set_en = 1'b1; sb_set_sel = 5'd3;
    tick();
    idle();
    wr_en = 1'b1; rd_sel = 5'd3; wr_data = 32'h33;
    sb_set_en = 1'b1; sb_set_sel = 5'd3;
    exp_q.push_back(32'h33);
    tick();
    idle(); rs1_sel = 5'd3; #1;
    exp = exp_q.pop_front();
    if (rs1_busy !== 1'b1 || busy_cnt !== 6'd1 || rs1_data !== exp) begin
      errors++; $display("FAIL simul got busy %b cnt %0d data %h exp 1 1 %h", rs1_busy, busy_cnt, rs1_data, exp);
    end
    checks++;
    wr_en = 1'b1; rd_sel = 5'd3; wr_data = 32'h34;
    tick();
    idle(); #1;
    if (busy_cnt !== 6'd0 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL simul_retire got cnt %0d busy %b exp 0 0", busy_cnt, rs1_busy);
    end
    checks++;
  endtask

  task automatic test_full();
    model_cnt = 0;
    for (int i = 1; i < 32; i++) begin
      sb_set_en = 1'b1; sb_set_sel = 5'(i);
      tick();
      model_cnt++;
      if (busy_cnt !== 6'(model_cnt) || sb_full !== (model_cnt == 31)) begin
        errors++; $display("FAIL fill_%0d got cnt %0d full %b exp %0d %b", i, busy_cnt, sb_full, model_cnt, model_cnt == 31);
      end
      checks++;
    end
    sb_set_sel = 5'd12;
    tick();
    if (busy_cnt !== 6'd31 || sb_full !== 1'b1) begin
      errors++; $display("FAIL reset_busy got cnt %0d full %b exp 31 1", busy_cnt, sb_full);
    end
    checks++;
    sb_set_sel = 5'd0;
    tick();
    idle(); rs1_sel = 5'd0; #1;
    if (busy_cnt !== 6'd31 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL set_x0 got cnt %0d busy %b exp 31 0", busy_cnt, rs1_busy);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; rd_sel = 5'd10; wr_data = 32'h10;
    tick();
    if (busy_cnt !== 6'd30 || sb_full !== 1'b0) begin
      errors++; $display("FAIL retire_from_full got cnt %0d full %b exp 30 0", busy_cnt, sb_full);
    end
    checks++;
    rd_sel = 5'd11; wr_data = 32'h11; sb_set_en = 1'b1; sb_set_sel = 5'd10;
    tick();
    idle(); rs1_sel = 5'd10; rs2_sel = 5'd11; #1;
    if (busy_cnt !== 6'd30 || rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
      errors++; $display("FAIL swap got cnt %0d b1 %b b2 %b exp 30 1 0", busy_cnt, rs1_busy, rs2_busy);
    end
    checks++;
    wr_en = 1'b1; rd_sel = 5'd11; wr_data = 32'h1111;
    exp_q.push_back(32'h1111);
    tick();
    idle(); #1;
    exp = exp_q.pop_front();
    if (busy_cnt !== 6'd30 || rs2_data !== exp) begin
      errors++; $display("FAIL write_idle got cnt %0d data %h exp 30 %h", busy_cnt, rs2_data, exp);
    end
    checks++;
    #2 rst = 1'b1; #1;
    if (busy_cnt !== 6'd0 || sb_full !== 1'b0 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got cnt %0d full %b busy %b exp 0 0 0", busy_cnt, sb_full, rs1_busy);
    end
    checks++;
    tick(); rst = 1'b0;
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; rd_sel = 5'd9; wr_data = 32'h11111111;
    tick();
    idle(); sb_set_en = 1'b1; sb_set_sel = 5'd9;
    tick();
    idle();
    rs1_sel = 5'd9; wr_en = 1'b1; rd_sel = 5'd9; wr_data = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hA5A5A5A5);
`else
    exp_q.push_back(32'h11111111);
`endif
    exp_q.push_back(32'hA5A5A5A5);
    #1;
    exp = exp_q.pop_front();
    if (rs1_data !== exp) begin errors++; $display("FAIL bypass_same got %h exp %h", rs1_data, exp); end
    checks++;
`ifdef REGFILE_BYPASS_EN
    if (rs1_busy !== 1'b0) begin errors++; $display("FAIL bypass_busy got %b exp 0", rs1_busy); end
`else
    if (rs1_busy !== 1'b1) begin errors++; $display("FAIL bypass_busy got %b exp 1", rs1_busy); end
`endif
    checks++;
    tick();
    idle(); #1;
    exp = exp_q.pop_front();
    if (rs1_data !== exp || rs1_busy !== 1'b0 || busy_cnt !== 6'd0) begin
      errors++; $display("FAIL bypass_next got %h/%b/%0d exp %h/0/0", rs1_data, rs1_busy, busy_cnt, exp);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_set_clear();
    test_simul_set_clear();
    test_full();
    test_back_to_back();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file for the single-cycle/multi-cycle CPU core, successor to the fixed 32x32 array. It provides two combinational read ports and one synchronous write port, with register 0 hardwired to zero. A per-register busy scoreboard tracks destinations of issued-but-unretired long-latency ops (cache-miss loads), so the core can stall on RAW hazards. An optional write-to-read bypass is also available.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers; power of two, at least 2
AW, $clog2(NREGS), register select width; derived, not overridden
CNT_W, $clog2(NREGS)+1, width of the outstanding-busy counter; derived

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
rs1_sel  input  AW  read port 1 register select
rs2_sel  input  AW  read port 2 register select
rs1_data  output  XLEN  read port 1 data
rs2_data  output  XLEN  read port 2 data
rs1_busy  output  1  rs1_sel has a pending write
rs2_busy  output  1  rs2_sel has a pending write
rd_sel  input  AW  write/retire register select
wr_data  input  XLEN  write data
wr_en  input  1  write strobe; also retires the busy bit of rd_sel
sb_set_en  input  1  mark sb_set_sel busy (issue of a long-latency op)
sb_set_sel  input  AW  register to mark busy
busy_cnt  output  CNT_W  number of registers currently busy
sb_full  output  1  every register 1..NREGS-1 is busy

Behaviour:
- Reset is asynchronous and active-high: clk is the clock, and rst asserted immediately clears all registers to 0 and all busy bits to 0. busy_cnt=0 and sb_full=0 while rst is high. Reset mid-sequence discards all pending busy state.
- Register 0 always reads 0 and is never busy. Writes and sb_set to index 0 are ignored.
- Write: on posedge clk, if wr_en and rd_sel!=0, reg[rd_sel] takes wr_data. Otherwise reg holds. Data is visible on read ports the following cycle (zero-latency only with bypass).
- Reads: purely combinational from the array.
- Busy bits update on posedge clk:
  - wr_en clears bit rd_sel.
  - sb_set_en sets bit sb_set_sel.
  - If both hit the same index in the same cycle, set wins and the bit stays 1 (new producer issued).
  - sb_set_en on an already-busy register leaves it 1 (no double count).
  - wr_en on a non-busy register is a plain write; the busy bit stays 0.
- rsN_busy = busy[rsN_sel] (combinational). It is 0 for index 0.
- busy_cnt is registered and equals the popcount of the busy vector after each edge. It is updated incrementally: +1 for set of a non-busy bit, -1 for clear of a busy bit, net 0 when both or neither occur. It never wraps, since the maximum is NREGS-1.
- sb_full = (busy_cnt == NREGS-1), combinational from the registered count.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: if wr_en and rd_sel!=0 and rd_sel==rsN_sel, then rsN_data=wr_data and rsN_busy=0 in the same cycle (forwarding and early retire).
- Undefined: read ports return only stored values. rsN_busy reflects the registered busy bit, so the reader sees the new data one cycle after the write.

Decomposition:
- Package regfile_pkg: XLEN/NREGS defaults, the reg_idx_t typedef (AW bits), the xlen_t typedef, and the ZERO_REG constant.
- One natural sub-module: busy_scoreboard. It owns the busy vector, busy_cnt, sb_full and the set/clear priority. The data array and read muxes stay in the top.

Test Plan:
- Reset and read: assert rst asynchronously mid-cycle. All rsN_data read 0, busy_cnt=0 and sb_full=0 before the next edge.
- Write then read: write reg 5 = 0xDEADBEEF, then read rs1_sel=5 on the next cycle to get 0xDEADBEEF. Writing reg 0 = 0x1234 still reads 0.
- Scoreboard set/clear: sb_set reg 7 gives rs2_busy=1 and busy_cnt=1. wr_en reg 7 = 0x55 clears it: busy=0, busy_cnt=0, data=0x55.
- Simultaneous set/clear: with reg 3 busy, drive wr_en rd_sel=3 and sb_set_en sb_set_sel=3 in one cycle. Reg 3 stays busy, busy_cnt is unchanged at 1, and data updates.
- Full scoreboard: set regs 1..31 on consecutive cycles. busy_cnt=31 and sb_full=1. Repeat sb_set 12 and busy_cnt stays 31. Then sb_set 0 and busy_cnt stays 31.
- Bypass: rs1_sel=9, wr_en rd_sel=9 wr_data=0xA5A5A5A5 in the same cycle.
  - Defined: rs1_data=0xA5A5A5A5 and rs1_busy=0 in that cycle.
  - Undefined: the old value is returned in that cycle and the new value the next cycle.
